delay_timer_mc: RTL and testbench
=================================

Name: delay_timer_mc

Overview:
- Multi-channel programmable millisecond delay timer for the 20 MHz system clock.
- Each channel is started independently. It runs for a delay chosen from a parameter table, then issues a one-cycle done pulse.
- Adds start/abort handshakes, busy status and optional retrigger, none of which the earlier single fixed-delay timer had.
- Sits between the control FSMs and any peripheral needing power-up or settle waits; each channel is owned by one FSM.

Parameters:
- NCH, 4, number of independent channels
- SEL_W, 2, width of the per-channel delay-select field; table has 2**SEL_W entries
- MS_W, 8, width of one table entry (delay in ms, 1..255)
- CLK_PER_MS, 20000, clk cycles per millisecond; must be >= 2; benches use 4
- MS_TABLE, {8'd100,8'd50,8'd20,8'd10}, packed delay table; entry i at bits [i*MS_W +: MS_W], so sel=0 gives 10 ms
- RETRIG, 1, 1 = start while busy restarts the delay; 0 = start while busy is ignored

Ports:
- clk  in  1  system clock, 20 MHz
- rst  in  1  asynchronous reset, active-low
- start  in  NCH  per-channel start request, sampled on the rising edge of clk; level or pulse accepted
- sel  in  NCH*SEL_W  per-channel table index, bits [c*SEL_W +: SEL_W]; sampled only when start is accepted
- abort  in  NCH  per-channel cancel
- busy  out  NCH  channel is timing
- done  out  NCH  one-cycle pulse at delay expiry

Behaviour:
- Reset (rst=0, asynchronous):
  - busy=0 and done=0 on all channels.
  - Prescaler and ms counters cleared; state IDLE.
  - Reset during RUN drops the delay silently, with no done pulse.
- Per-channel FSM, states IDLE and RUN.
- Delay definition:
  - Table entry value 0 is treated as 1.
  - D = entry(sel) * CLK_PER_MS cycles.
  - Prescaler width clog2(CLK_PER_MS); ms counter width MS_W; no wrap is possible.
- Start sampled in cycle 0 (IDLE, start=1, abort=0):
  - sel is latched.
  - busy=1 from cycle 1 through cycle D inclusive.
  - done=1 in cycle D only; busy=0 from cycle D+1.
  - Exactly D cycles from start to done.
- Counting:
  - The prescaler counts 0..CLK_PER_MS-1.
  - Each prescaler wrap decrements the ms counter.
  - done fires on the final wrap, when the ms counter reaches 1.
- A level start held high restarts at the cycle after done. Back-to-back period is D+1 cycles unless the start-at-done rule below applies.
- Start in RUN:
  - RETRIG=1: counters reload and sel is re-latched. The new D counts from that cycle; busy stays high and no done is issued for the old delay.
  - RETRIG=0: start is ignored.
- Start in the same cycle as done (cycle D): done still pulses. RETRIG=1 restarts immediately, so busy stays high in D+1. RETRIG=0 is idle at D+1.
- Abort:
  - Abort in RUN: busy=0 next cycle, counters cleared, no done.
  - Abort has priority over start in the same cycle: the channel ends or stays in IDLE.
  - Abort in cycle D suppresses done.
  - Abort in IDLE has no effect.
- sel changes while in RUN are ignored.
- Channels are fully independent; no shared prescaler, so there is no start-phase jitter.

Decomposition:
- Package delay_timer_pkg:
  - state enum {IDLE, RUN}
  - default CLK_PER_MS_20MHZ = 20000
  - default 4-entry table constant
  - helper function returning a table entry with the 0-to-1 clamp
- Sub-module delay_timer_ch: one channel (FSM, prescaler, ms counter, latched sel).
  - Instanced NCH times in a generate loop.
  - Receives MS_TABLE, CLK_PER_MS, RETRIG and its own start/sel/abort slice.
- Top level does only slicing and concatenation.

Test Plan:
- Reset/idle: CLK_PER_MS=4. Hold rst=0 5 cycles, release with start=0 -> busy=0 and done=0 on all channels for 20 cycles.
- Nominal timing: ch0 start pulse with sel=0 (10 ms) -> busy high cycles 1..40, done only at cycle 40, busy=0 at cycle 41. Repeat with sel=3 -> done at cycle 400.
- Retrigger: RETRIG=1, ch1 sel=0, start at cycle 0 and again at cycle 25 with sel=1 -> no done at 40; done at cycle 25+80=105; busy continuous. With RETRIG=0 -> done at 40, second start ignored.
- Abort: ch2 start at 0 (sel=0), abort at 30 -> busy=0 at 31, no done ever. Start+abort in the same cycle from IDLE -> stays idle. Abort at cycle 40 -> no done.
- Start at expiry: ch3 start held high continuously, sel=0 -> done at cycle 40. RETRIG=1: busy never drops and the next done is at 80. RETRIG=0: busy=0 at 41 and restart gives done at 81.
- Independence/reset mid-run: start all channels with different sel on staggered cycles -> each done at its own start+D. Then assert rst mid-run -> all outputs 0 at once and no done after release.

Source files
------------

// File: rtl/delay_timer_pkg.sv
// Shared types, defaults and the delay-table lookup for the multi-channel delay timer.
package delay_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int CLK_PER_MS_20MHZ = 20000;

  // Four 8-bit entries, entry 0 in the low byte: sel=0 -> 10 ms, sel=3 -> 100 ms.
  localparam logic [31:0] DEF_MS_TABLE = {8'd100, 8'd50, 8'd20, 8'd10};

  // Upper bounds for the generic table lookup below.
  localparam int MAX_MS_W  = 32;
  localparam int MAX_TBL_W = 1024;

  // Returns entry idx of a packed table of ms_w-bit entries; a zero entry reads as 1 ms.
  function automatic logic [MAX_MS_W-1:0] ms_entry(
    input logic [MAX_TBL_W-1:0] tbl,
    input int                   idx,
    input int                   ms_w
  );
    logic [MAX_MS_W-1:0] v;
    v = '0;
    for (int b = 0; b < MAX_MS_W; b++) begin
      if (b < ms_w) begin
        v[b] = tbl[idx*ms_w + b];
      end else begin
        v[b] = 1'b0;
      end
    end
    if (v == '0) begin
      v = MAX_MS_W'(1);
    end else begin
      v = v;
    end
    return v;
  endfunction

endpackage

// File: rtl/delay_timer_if.sv
// Start/abort/status bundle between the owning control FSMs and the delay timer.
interface delay_timer_if #(
  parameter int NCH   = 4,
  parameter int SEL_W = 2
) ();

  logic [NCH-1:0]       start;
  logic [NCH*SEL_W-1:0] sel;
  logic [NCH-1:0]       abort;
  logic [NCH-1:0]       busy;
  logic [NCH-1:0]       done;

  modport master (
    output start, sel, abort,
    input  busy, done
  );

  modport slave (
    input  start, sel, abort,
    output busy, done
  );

endinterface

// File: rtl/delay_timer_ch.sv
// One delay channel: IDLE/RUN FSM, private prescaler and ms down-counter.
module delay_timer_ch
  import delay_timer_pkg::*;
#(
  parameter int                             SEL_W      = 2,
  parameter int                             MS_W       = 8,
  parameter int                             CLK_PER_MS = CLK_PER_MS_20MHZ,
  parameter logic [(2**SEL_W)*MS_W-1:0]     MS_TABLE   = DEF_MS_TABLE,
  parameter int                             RETRIG     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W-1:0] sel,
  input  logic             abort,
  output logic             busy,
  output logic             done
);

  localparam int                     PW      = $clog2(CLK_PER_MS);
  localparam logic [PW-1:0]          PRE_MAX = PW'(CLK_PER_MS - 1);
  localparam logic [MAX_TBL_W-1:0]   TBL_EXT = MAX_TBL_W'(MS_TABLE);

  state_t          state_r, state_n;
  logic [PW-1:0]   pre_r, pre_n;
  logic [MS_W-1:0] ms_r, ms_n;
  logic            start_q_r;
  logic [MS_W-1:0] load_s;
  logic            expire_s;
  logic            retrig_s;

  // Loading the ms counter from the table is what latches sel; later sel changes are not looked at.
  assign load_s   = MS_W'(ms_entry(TBL_EXT, int'(sel), MS_W));
  assign expire_s = (state_r == RUN) && (pre_r == PRE_MAX) && (ms_r == MS_W'(1));
  // In RUN a retrigger needs a fresh start edge, so a held start cannot pin the channel forever;
  // at expiry a held level is enough, giving the seamless restart.
  assign retrig_s = (RETRIG != 0) && start && (!start_q_r || expire_s);

  assign busy = (state_r == RUN);
  assign done = expire_s && !abort;

  // State and counter registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      pre_r     <= '0;
      ms_r      <= '0;
      start_q_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      pre_r     <= pre_n;
      ms_r      <= ms_n;
      start_q_r <= start;
    end
  end

  // Next-state logic: abort first, then (re)start, then expiry, then counting.
  always_comb begin
    state_n = state_r;
    pre_n   = pre_r;
    ms_n    = ms_r;
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          state_n = RUN;
          pre_n   = '0;
          ms_n    = load_s;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
          pre_n   = '0;
          ms_n    = '0;
        end else if (retrig_s) begin
          state_n = RUN;
          pre_n   = '0;
          ms_n    = load_s;
        end else if (expire_s) begin
          state_n = IDLE;
          pre_n   = '0;
          ms_n    = '0;
        end else if (pre_r == PRE_MAX) begin
          pre_n = '0;
          ms_n  = ms_r - MS_W'(1);
        end else begin
          pre_n = pre_r + PW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        pre_n   = '0;
        ms_n    = '0;
      end
    endcase
  end

endmodule

// File: rtl/delay_timer_mc.sv
// Multi-channel delay timer: slices the bus into NCH independent channels.
module delay_timer_mc
  import delay_timer_pkg::*;
#(
  parameter int                         NCH        = 4,
  parameter int                         SEL_W      = 2,
  parameter int                         MS_W       = 8,
  parameter int                         CLK_PER_MS = CLK_PER_MS_20MHZ,
  parameter logic [(2**SEL_W)*MS_W-1:0] MS_TABLE   = DEF_MS_TABLE,
  parameter int                         RETRIG     = 1
) (
  input logic           clk,
  input logic           rst,
  delay_timer_if.slave  bus
);

  logic [NCH-1:0] busy_s;
  logic [NCH-1:0] done_s;

  assign bus.busy = busy_s;
  assign bus.done = done_s;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    delay_timer_ch #(
      .SEL_W      (SEL_W),
      .MS_W       (MS_W),
      .CLK_PER_MS (CLK_PER_MS),
      .MS_TABLE   (MS_TABLE),
      .RETRIG     (RETRIG)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .start (bus.start[c]),
      .sel   (bus.sel[c*SEL_W +: SEL_W]),
      .abort (bus.abort[c]),
      .busy  (busy_s[c]),
      .done  (done_s[c])
    );
  end

endmodule

// File: tb/tb_delay_timer_mc.sv
// Directed bench: one retriggering and one non-retriggering instance driven in lockstep.
module tb_delay_timer_mc;

  logic       clk;
  logic       rst;
  logic [3:0] start_v;
  logic [3:0] abort_v;
  logic [7:0] sel_v;
  int         checks;
  int         failures;
  int         kcur;

  delay_timer_if #(.NCH(4), .SEL_W(2)) bus1 ();
  delay_timer_if #(.NCH(4), .SEL_W(2)) bus0 ();

  assign bus1.start = start_v;
  assign bus1.abort = abort_v;
  assign bus1.sel   = sel_v;
  assign bus0.start = start_v;
  assign bus0.abort = abort_v;
  assign bus0.sel   = sel_v;

  delay_timer_mc #(.NCH(4), .SEL_W(2), .MS_W(8), .CLK_PER_MS(4),
                   .MS_TABLE({8'd100, 8'd50, 8'd20, 8'd10}), .RETRIG(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  delay_timer_mc #(.NCH(4), .SEL_W(2), .MS_W(8), .CLK_PER_MS(4),
                   .MS_TABLE({8'd100, 8'd50, 8'd20, 8'd10}), .RETRIG(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, kcur, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] b1, input logic [3:0] d1,
                         input logic [3:0] b0, input logic [3:0] d0);
    chk({tag, ".busy_rt1"}, bus1.busy, b1);
    chk({tag, ".done_rt1"}, bus1.done, d1);
    chk({tag, ".busy_rt0"}, bus0.busy, b0);
    chk({tag, ".done_rt0"}, bus0.done, d0);
  endtask

  // Advance to the next cycle, apply this cycle's inputs, then let combinational outputs settle.
  task automatic step(input logic [3:0] st, input logic [3:0] ab, input logic [7:0] sl);
    @(posedge clk);
    #1;
    start_v = st;
    abort_v = ab;
    sel_v   = sl;
    #1;
  endtask

  initial begin
    int         s[4];
    int         d[4];
    logic [3:0] eb, ed, st;
    checks   = 0;
    failures = 0;
    kcur     = 0;
    rst      = 1'b0;
    start_v  = 4'b0000;
    abort_v  = 4'b0000;
    sel_v    = 8'h00;

    // Reset held for 5 cycles, then 20 idle cycles.
    #1;
    chk_all("reset_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      kcur = k;
      step(4'b0000, 4'b0000, 8'h00);
      chk_all("reset_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      kcur = k;
      step(4'b0000, 4'b0000, 8'h00);
      chk_all("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end

    // ch0 pulse start, sel=0 -> D=40.
    kcur = 0;
    step(4'b0001, 4'b0000, 8'h00);
    chk_all("nom10_c0", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 1; k <= 41; k++) begin
      kcur = k;
      step(4'b0000, 4'b0000, 8'hFF);
      eb = {3'b000, (k <= 40)};
      ed = {3'b000, (k == 40)};
      chk_all("nom10", eb, ed, eb, ed);
    end

    // ch0 pulse start, sel=3 -> D=400.
    kcur = 0;
    step(4'b0001, 4'b0000, 8'h03);
    for (int k = 1; k <= 401; k++) begin
      kcur = k;
      step(4'b0000, 4'b0000, 8'h00);
      eb = {3'b000, (k <= 400)};
      ed = {3'b000, (k == 400)};
      chk_all("nom100", eb, ed, eb, ed);
    end

    // ch1 retrigger at cycle 25 with sel=1 (D=80).
    kcur = 0;
    step(4'b0010, 4'b0000, 8'h00);
    for (int k = 1; k <= 106; k++) begin
      kcur = k;
      if (k == 25) begin
        step(4'b0010, 4'b0000, 8'h04);
      end else begin
        step(4'b0000, 4'b0000, 8'h00);
      end
      chk_all("retrig", {2'b00, (k <= 105), 1'b0}, {2'b00, (k == 105), 1'b0},
                        {2'b00, (k <= 40), 1'b0},  {2'b00, (k == 40), 1'b0});
    end

    // ch2 abort at cycle 30: no done ever.
    kcur = 0;
    step(4'b0100, 4'b0000, 8'h00);
    for (int k = 1; k <= 45; k++) begin
      kcur = k;
      step(4'b0000, (k == 30) ? 4'b0100 : 4'b0000, 8'h00);
      eb = {1'b0, (k <= 30), 2'b00};
      chk_all("abort30", eb, 4'b0000, eb, 4'b0000);
    end

    // Start and abort together from IDLE: stays idle.
    kcur = 0;
    step(4'b0100, 4'b0100, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      kcur = k;
      step(4'b0000, 4'b0000, 8'h00);
      chk_all("start_abort", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end

    // Abort in the expiry cycle suppresses done.
    kcur = 0;
    step(4'b0100, 4'b0000, 8'h00);
    for (int k = 1; k <= 42; k++) begin
      kcur = k;
      step(4'b0000, (k == 40) ? 4'b0100 : 4'b0000, 8'h00);
      eb = {1'b0, (k <= 40), 2'b00};
      chk_all("abort40", eb, 4'b0000, eb, 4'b0000);
    end

    // ch3 start held high, sel=0.
    for (int k = 0; k <= 85; k++) begin
      kcur = k;
      step(4'b1000, 4'b0000, 8'h00);
      chk_all("held", {(k >= 1), 3'b000}, {(k == 40 || k == 80), 3'b000},
                      {((k >= 1 && k <= 40) || (k >= 42 && k <= 81) || k >= 83), 3'b000},
                      {(k == 40 || k == 81), 3'b000});
    end
    kcur = 86;
    step(4'b0000, 4'b1000, 8'h00);
    chk_all("held_abort", 4'b1000, 4'b0000, 4'b1000, 4'b0000);
    kcur = 87;
    step(4'b0000, 4'b0000, 8'h00);
    chk_all("held_clear", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // All channels, staggered starts, distinct delays.
    s = '{0, 3, 5, 7};
    d = '{40, 80, 200, 400};
    for (int k = 0; k <= 410; k++) begin
      kcur = k;
      for (int c = 0; c < 4; c++) begin
        st[c] = (k == s[c]);
        eb[c] = (k > s[c]) && (k <= s[c] + d[c]);
        ed[c] = (k == s[c] + d[c]);
      end
      step(st, 4'b0000, 8'hE4);
      chk_all("indep", eb, ed, eb, ed);
    end

    // Reset mid-run: outputs drop at once, nothing fires after release.
    kcur = 0;
    step(4'b1111, 4'b0000, 8'hE4);
    for (int k = 1; k <= 20; k++) begin
      kcur = k;
      step(4'b0000, 4'b0000, 8'hE4);
    end
    chk_all("pre_rst", 4'b1111, 4'b0000, 4'b1111, 4'b0000);
    rst = 1'b0;
    #1;
    chk_all("rst_mid", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      step(4'b0000, 4'b0000, 8'hE4);
    end
    rst = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      kcur = k;
      step(4'b0000, 4'b0000, 8'hE4);
      chk_all("post_rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
